mmio_controller: RTL and testbench
==================================

// Module: mmio_controller
// PURPOSE
//  Sits between processor data-memory port and RAM/MMIO devices. Decodes address_dmem, gates RAM writes,
//  owns the MIDI receive byte FIFO, drives xorshift advance and sevenseg writes.
//  Returns read data with RAM-matched one-cycle latency.
// PARAMETERS
//  MMIO_BASE   32'h2000      first MMIO address; lower addresses go to RAM
//  FIFO_DEPTH  16            MIDI byte FIFO entries; power of 2, >=2
//  POISON      32'hfbadc0de  read value for unmapped MMIO addresses
// PORTS
//  clock          in   1   system clock, all state updates on posedge
//  reset          in   1   synchronous, active-high
//  mem_ren        in   1   processor read request
//  wren           in   1   processor write request
//  address_dmem   in   32  processor word address
//  data           in   32  processor write data
//  q_dmem         out  32  read data to processor, valid cycle after request
//  ram_dout       in   32  RAM dataOut (synchronous read)
//  ram_wen        out  1   RAM write enable
//  rng_data       in   32  xorshift current value
//  rng_next       out  1   xorshift advance strobe
//  midi_byte      in   8   received MIDI byte
//  midi_valid     in   1   midi_byte valid, 1-cycle pulse per byte
//  sevenseg_writeEnable out 1  1-cycle write pulse
//  sevenseg_data  out  32  last value written to sevenseg
// BEHAVIOUR
//  Map (MMIO_BASE+): +0 STATUS r, +1 RNG r, +2 MIDI_DATA r, +3 SEVENSEG w, +4 TIMER r/w (optional).
//  is_mmio = address_dmem >= MMIO_BASE. ram_wen = wren & ~is_mmio (combinational).
//  Read: edge of request registers sel_q = is_mmio & mem_ren and mmio_q. q_dmem = sel_q ? mmio_q : ram_dout.
//  STATUS = {ovf[31], 13'b0, full[17], empty[16], 16-bit count}. Reading STATUS clears ovf.
//   If overflow and STATUS read coincide, ovf stays set.
//  RNG: rng_next = mem_ren & ~wren & (addr==+1), combinational. mmio_q captures pre-advance rng_data.
//  MIDI_DATA read: returns {23'b0, empty, head byte}. Pops when non-empty.
//   When empty: returns 32'h100, pointers unchanged.
//  FIFO push: on midi_valid. If full and no pop this cycle: byte dropped, ovf set (sticky).
//   Push and pop in the same cycle both take effect, including when full, so count is unchanged.
//  Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2+1 bits, 0..FIFO_DEPTH.
//  SEVENSEG write: sevenseg_data <= data; sevenseg_writeEnable = 1 on the following cycle only.
//  Write to read-only or unmapped MMIO: ignored, RAM untouched.
//  Read of unmapped or write-only address: POISON.
//  mem_ren & wren together: treated as write. No pop, no rng_next, sel_q=0.
//  Reset (any cycle, incl. mid-read): pointers/count/ovf=0, sel_q=0, mmio_q=0, sevenseg_data=0,
//   sevenseg_writeEnable=0, timer=0. midi_valid is ignored while reset is high.
//   q_dmem follows ram_dout after reset.
// CONFIGURATION
//  MMIO_TIMER_EN defined: 32-bit free-running cycle counter at +4.
//   Read returns count at the request edge; it wraps at 2^32.
//   Any write to +4 zeroes the counter: next-cycle value 0, then counting resumes.
//  Not defined: +4 is unmapped (reads POISON, writes ignored), no counter flops.
// STRUCTURE
//  Package mmio_pkg: MMIO offset constants, STATUS bit positions, POISON default, EMPTY_READ (32'h100).
//  Sub-module midi_fifo (param DEPTH): push/pop/full/empty/count/head, simultaneous push+pop rule.
//   Overflow flag and decode live in mmio_controller.
// TESTING
//  Reset, read 0x2000 -> q_dmem=32'h00010000 next cycle. Read 0x2002 -> 32'h100.
//  Push 0x90,0x3C,0x7F; read 0x2002 x3 -> 0x90,0x3C,0x7F in order. STATUS then 0x00010000.
//  Push 17 bytes with DEPTH=16 -> STATUS=0x8002_0010. Second STATUS read -> 0x0002_0010.
//  Full FIFO, midi_valid and MIDI_DATA read same cycle -> count stays 16, ovf stays 0, new byte lands at tail.
//  Write 0xBEEF to 0x2003 -> sevenseg_data=0xBEEF, 1-cycle pulse. Write 0x1FFF -> ram_wen=1.
//   Write 0x2000 -> ram_wen=0.
//  Read 0x2001 -> rng_next 1 cycle, q_dmem=0xdeadbeef (seeded). Read 0x2010 -> 0xfbadc0de.
//   With MMIO_TIMER_EN: write 0x2004 then read -> small count.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory MMIO decoder: register offsets,
// STATUS bit positions and fixed read values.
package mmio_pkg;

  localparam logic [31:0] OFS_STATUS   = 32'd0;
  localparam logic [31:0] OFS_RNG      = 32'd1;
  localparam logic [31:0] OFS_MIDI     = 32'd2;
  localparam logic [31:0] OFS_SEVENSEG = 32'd3;
  localparam logic [31:0] OFS_TIMER    = 32'd4;

  localparam int STATUS_OVF_BIT   = 31;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_EMPTY_BIT = 16;

  localparam logic [31:0] POISON_DEFAULT = 32'hfbadc0de;
  localparam logic [31:0] EMPTY_READ     = 32'h0000_0100;

endpackage

// File: rtl/mmio_controller_midi_fifo.sv
// MIDI receive byte FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise the caller sees it as an overflow.
module midi_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_en = push & (~full | pop);
  assign pop_en  = pop & ~empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_controller.sv
// Data-memory address decoder for RAM and MMIO devices (STATUS, RNG, MIDI,
// SEVENSEG). Define MMIO_TIMER_EN to add a free-running cycle timer at +4.
module mmio_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'h2000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] POISON     = POISON_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_ren,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_dmem,
  input  logic [31:0] ram_dout,
  output logic        ram_wen,
  input  logic [31:0] rng_data,
  output logic        rng_next,
  input  logic [7:0]  midi_byte,
  input  logic        midi_valid,
  output logic        sevenseg_writeEnable,
  output logic [31:0] sevenseg_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          is_mmio;
  logic [31:0]   offset;
  logic          rd_req;
  logic          mmio_rd;
  logic          mmio_wr;
  logic          sel_q;
  logic [31:0]   mmio_q;
  logic [31:0]   mmio_rdata;
  logic [31:0]   status_word;
  logic          ovf;
  logic          ovf_set;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // A cycle with both mem_ren and wren is a write: it never pops, advances
  // the RNG or selects MMIO read data.
  assign is_mmio  = (address_dmem >= MMIO_BASE);
  assign offset   = address_dmem - MMIO_BASE;
  assign rd_req   = mem_ren & ~wren;
  assign mmio_rd  = rd_req & is_mmio;
  assign mmio_wr  = wren & is_mmio;
  assign ram_wen  = wren & ~is_mmio;
  assign rng_next = mmio_rd & (offset == OFS_RNG);

  // midi_valid is a one-cycle strobe with no ready: a byte arriving at a full
  // FIFO without a pop in the same cycle is dropped and latched in ovf.
  assign fifo_push = midi_valid & ~reset;
  assign fifo_pop  = mmio_rd & (offset == OFS_MIDI) & ~fifo_empty;
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;

  midi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (midi_byte),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                   = '0;
    status_word[15:0]             = 16'(fifo_count);
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_OVF_BIT]   = ovf;
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clock) begin
    if (reset)                                timer <= '0;
    else if (mmio_wr && offset == OFS_TIMER)  timer <= '0;
    else                                      timer <= timer + 32'd1;
  end
`endif

  always_comb begin
    mmio_rdata = POISON;
    case (offset)
      OFS_STATUS: mmio_rdata = status_word;
      OFS_RNG:    mmio_rdata = rng_data;
      OFS_MIDI:   mmio_rdata = fifo_empty ? EMPTY_READ : {23'b0, 1'b0, fifo_head};
`ifdef MMIO_TIMER_EN
      OFS_TIMER:  mmio_rdata = timer;
`endif
      default:    mmio_rdata = POISON;
    endcase
  end

  // A STATUS read clears ovf unless a new overflow lands in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf                  <= 1'b0;
      sel_q                <= 1'b0;
      mmio_q               <= '0;
      sevenseg_data        <= '0;
      sevenseg_writeEnable <= 1'b0;
    end else begin
      if (ovf_set)                                ovf <= 1'b1;
      else if (mmio_rd && offset == OFS_STATUS)   ovf <= 1'b0;
      sel_q <= mmio_rd;
      if (mmio_rd) mmio_q <= mmio_rdata;
      sevenseg_writeEnable <= mmio_wr && (offset == OFS_SEVENSEG);
      if (mmio_wr && offset == OFS_SEVENSEG) sevenseg_data <= data;
    end
  end

  assign q_dmem = sel_q ? mmio_q : ram_dout;

endmodule

// File: tb/tb_mmio_controller.sv
// Self-checking bench for mmio_controller: constant vector table, hand-written
// FIFO/overflow/reset sequences and random traffic against a queue-based model.
module tb_mmio_controller;

  localparam logic [31:0] BASE   = 32'h2000;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] POISON = 32'hfbadc0de;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_ren;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic [31:0] ram_dout;
  logic        ram_wen;
  logic [31:0] rng_data;
  logic        rng_next;
  logic [7:0]  midi_byte;
  logic        midi_valid;
  logic        sevenseg_writeEnable;
  logic [31:0] sevenseg_data;

  mmio_controller #(.MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH), .POISON(POISON)) dut (
    .clock                (clock),
    .reset                (reset),
    .mem_ren              (mem_ren),
    .wren                 (wren),
    .address_dmem         (address_dmem),
    .data                 (data),
    .q_dmem               (q_dmem),
    .ram_dout             (ram_dout),
    .ram_wen              (ram_wen),
    .rng_data             (rng_data),
    .rng_next             (rng_next),
    .midi_byte            (midi_byte),
    .midi_valid           (midi_valid),
    .sevenseg_writeEnable (sevenseg_writeEnable),
    .sevenseg_data        (sevenseg_data)
  );

  // ---------------- clock / environment ----------------
  always #5 clock = ~clock;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  logic [31:0] tb_ram [64];

  always @(posedge clock) begin
    ram_dout <= tb_ram[address_dmem[5:0]];
    if (ram_wen) tb_ram[address_dmem[5:0]] <= data;
  end

  always @(posedge clock) begin
    if (reset)         rng_data <= 32'hdeadbeef;
    else if (rng_next) rng_data <= xs(rng_data);
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_fifo[$];
  logic        m_ovf;
  logic [31:0] m_seg;
  logic        m_pulse;
  logic [31:0] m_ram [64];
  int unsigned m_timer;
  logic [31:0] exp_q[$];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ovf   = 1'b0;
    m_seg   = '0;
    m_pulse = 1'b0;
    m_timer = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] dat, input logic mv, input logic [7:0] mb,
                            output logic rd, output logic [31:0] q_e,
                            output logic wen_e, output logic rn_e);
    bit          mm;
    logic [31:0] off;
    bit          popped;
    bit          ovf_now;
    int          n;
    mm     = (addr >= BASE);
    off    = addr - BASE;
    rd     = ren && !wen;
    wen_e  = wen && !mm;
    rn_e   = rd && mm && (off == 1);
    q_e    = '0;
    popped = 0;
    n      = m_fifo.size();
    if (rd && !mm) q_e = m_ram[addr[5:0]];
    else if (rd) begin
      if (off == 0)      q_e = {m_ovf, 13'b0, n == DEPTH, n == 0, 16'(n)};
      else if (off == 1) q_e = rng_data;
      else if (off == 2) q_e = (n == 0) ? 32'h100 : {24'b0, m_fifo[0]};
`ifdef MMIO_TIMER_EN
      else if (off == 4) q_e = m_timer;
`endif
      else               q_e = POISON;
    end
    if (rd && mm && off == 2 && n > 0) begin
      void'(m_fifo.pop_front());
      popped = 1;
    end
    ovf_now = 0;
    if (mv) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(mb);
      else                       ovf_now = 1;
    end
    if (ovf_now)                      m_ovf = 1'b1;
    else if (rd && mm && off == 0)    m_ovf = 1'b0;
    m_pulse = wen && mm && (off == 3);
    if (m_pulse) m_seg = dat;
    if (wen_e) m_ram[addr[5:0]] = dat;
    if (wen && mm && off == 4) m_timer = 0;
    else                       m_timer = m_timer + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] dat, input logic mv, input logic [7:0] mb);
    logic rd, wen_e, rn_e;
    logic [31:0] q_e;
    mem_ren = ren; wren = wen; address_dmem = addr; data = dat;
    midi_valid = mv; midi_byte = mb;
    #1;
    model_step(ren, wen, addr, dat, mv, mb, rd, q_e, wen_e, rn_e);
    check("ram_wen", 32'(ram_wen), 32'(wen_e));
    check("rng_next", 32'(rng_next), 32'(rn_e));
    if (rd) exp_q.push_back(q_e);
    @(negedge clock);
    if (rd) check("q_dmem", q_dmem, exp_q.pop_front());
    check("seg_data", sevenseg_data, m_seg);
    check("seg_we", 32'(sevenseg_writeEnable), 32'(m_pulse));
    mem_ren = 1'b0; wren = 1'b0; midi_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr);
    apply(1'b1, 1'b0, addr, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ren = 1'b0; wren = 1'b0; address_dmem = '0; data = '0;
    midi_valid = 1'b1; midi_byte = 8'($urandom);
    repeat (2) @(negedge clock);
    reset = 1'b0; midi_valid = 1'b0;
    model_reset();
    check("rst_seg_data", sevenseg_data, 32'h0);
    check("rst_seg_we", 32'(sevenseg_writeEnable), 32'h0);
    check("rst_q_ram", q_dmem, m_ram[0]);
  endtask

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        mv;
    logic [7:0]  mb;
    logic        chk;
    logic [31:0] exp_v;
  } tv_t;

  tv_t tbl[$];

  initial begin : main
    logic [31:0] last_q;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 64; i++) begin
      tb_ram[i] = 32'h5500_0000 + 32'(i) * 32'h0001_0101;
      m_ram[i]  = 32'h5500_0000 + 32'(i) * 32'h0001_0101;
    end

    tbl.push_back('{1, 0, 32'h2000, 32'h0,        0, 8'h00, 1, 32'h0001_0000});
    tbl.push_back('{1, 0, 32'h2002, 32'h0,        0, 8'h00, 1, 32'h0000_0100});
    tbl.push_back('{0, 0, 32'h0000, 32'h0,        1, 8'h90, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0000, 32'h0,        1, 8'h3C, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0000, 32'h0,        1, 8'h7F, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h2000, 32'h0,        0, 8'h00, 1, 32'h0000_0003});
    tbl.push_back('{1, 0, 32'h2002, 32'h0,        0, 8'h00, 1, 32'h0000_0090});
    tbl.push_back('{1, 0, 32'h2002, 32'h0,        0, 8'h00, 1, 32'h0000_003C});
    tbl.push_back('{1, 0, 32'h2002, 32'h0,        0, 8'h00, 1, 32'h0000_007F});
    tbl.push_back('{1, 0, 32'h2000, 32'h0,        0, 8'h00, 1, 32'h0001_0000});
    tbl.push_back('{0, 1, 32'h2003, 32'hBEEF,     0, 8'h00, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0000, 32'h0,        0, 8'h00, 0, 32'h0});
    tbl.push_back('{0, 1, 32'h1FFF, 32'h12345678, 0, 8'h00, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h1FFF, 32'h0,        0, 8'h00, 1, 32'h12345678});
    tbl.push_back('{0, 1, 32'h2000, 32'h5,        0, 8'h00, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h2000, 32'h0,        0, 8'h00, 1, 32'h0001_0000});
    tbl.push_back('{1, 0, 32'h2001, 32'h0,        0, 8'h00, 1, 32'hdeadbeef});
    tbl.push_back('{1, 0, 32'h2010, 32'h0,        0, 8'h00, 1, 32'hfbadc0de});
    tbl.push_back('{1, 0, 32'h2003, 32'h0,        0, 8'h00, 1, 32'hfbadc0de});
    tbl.push_back('{1, 1, 32'h2001, 32'h0,        0, 8'h00, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h2001, 32'h0,        0, 8'h00, 1, xs(32'hdeadbeef)});
    tbl.push_back('{1, 1, 32'h2002, 32'h0,        1, 8'h44, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h2000, 32'h0,        0, 8'h00, 1, 32'h0000_0001});
    tbl.push_back('{1, 0, 32'h2002, 32'h0,        0, 8'h00, 1, 32'h0000_0044});

    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].dat, tbl[i].mv, tbl[i].mb);
      if (tbl[i].chk) check($sformatf("tbl%0d", i), q_dmem, tbl[i].exp_v);
    end

    // overflow: 17 pushes into 16 entries, STATUS read clears ovf
    do_reset();
    for (int i = 0; i < 17; i++) apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'(8'h10 + i));
    rd(32'h2000); check("ovf_status", q_dmem, 32'h8002_0010);
    rd(32'h2000); check("ovf_cleared", q_dmem, 32'h0002_0010);

    // full FIFO: push and pop together keep count, new byte lands at tail
    apply(1'b1, 1'b0, 32'h2002, 32'h0, 1'b1, 8'hA5);
    check("full_pushpop_head", q_dmem, 32'h10);
    rd(32'h2000); check("full_pushpop_status", q_dmem, 32'h0002_0010);
    last_q = '0;
    for (int i = 0; i < 16; i++) begin
      rd(32'h2002);
      last_q = q_dmem;
    end
    check("drain_tail", last_q, 32'hA5);
    rd(32'h2000); check("drained_status", q_dmem, 32'h0001_0000);

    // overflow coinciding with a STATUS read leaves ovf set
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'(i));
    apply(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 8'hEE);
    check("coincide_pre", q_dmem, 32'h0002_0010);
    rd(32'h2000); check("coincide_kept", q_dmem, 32'h8002_0010);
    rd(32'h2000); check("coincide_clr", q_dmem, 32'h0002_0010);

    // read+write together on MIDI_DATA must not pop
    apply(1'b1, 1'b1, 32'h2002, 32'h77, 1'b0, 8'h0);
    rd(32'h2000); check("rw_no_pop", q_dmem, 32'h0002_0010);

    // reset asserted on a read edge: q follows RAM, outputs cleared
    apply(1'b0, 1'b1, 32'h2003, 32'hCAFE, 1'b0, 8'h0);
    reset = 1'b1; mem_ren = 1'b1; address_dmem = 32'h2002;
    @(negedge clock);
    check("rst_mid_q", q_dmem, m_ram[2]);
    check("rst_mid_seg", sevenseg_data, 32'h0);
    check("rst_mid_we", 32'(sevenseg_writeEnable), 32'h0);
    reset = 1'b0; mem_ren = 1'b0;
    model_reset();
    rd(32'h2000); check("rst_mid_status", q_dmem, 32'h0001_0000);

`ifdef MMIO_TIMER_EN
    apply(1'b0, 1'b1, 32'h2004, 32'h1234, 1'b0, 8'h0);
    rd(32'h2004); check("timer_zero", q_dmem, 32'h0);
    repeat (3) apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0);
    rd(32'h2004); check("timer_count", q_dmem, 32'h4);
`else
    apply(1'b0, 1'b1, 32'h2004, 32'h1234, 1'b0, 8'h0);
    rd(32'h2004); check("timer_absent", q_dmem, POISON);
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      a = BASE + 32'(k);
      else if (k == 6) a = BASE + 32'h10;
      else if (k == 7) a = BASE + 32'($urandom_range(5, 255));
      else             a = 32'h1FC0 + 32'($urandom_range(0, 63));
      k = $urandom_range(0, 9);
      apply(k != 6 && k != 7 && k != 8, k >= 6, a, $urandom,
            $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
